// File: rtl/riscv_core_pkg.sv
// Shared types and constants for the memory read arbiter.
//   XLEN          - data width of the read data path
//   REQ_ICACHE/REQ_DCACHE - requester index constants (bit positions in the 2-bit vectors)
//   arb_state_e   - arbiter FSM state encoding
//   req_onehot()  - converts a 1-bit requester index into a one-hot 2-bit vector
package riscv_core_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REQ_ICACHE = 0;
    localparam int unsigned REQ_DCACHE = 1;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData
    } arb_state_e;

    function automatic logic [1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_read_arbiter_if.sv
// Bus bundle between two cache requesters, the arbiter and a downstream memory.
//   req_*  - per-requester read-address / read-data handshakes (bit 0 icache, bit 1 dcache)
//   mem_*  - single downstream read-address / read-data channel
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (requesters plus memory model)
interface mem_read_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    import riscv_core_pkg::*;

    logic [1:0]                 req_arvalid_i;
    logic [1:0][ADDR_WIDTH-1:0] req_araddr_i;
    logic [1:0]                 req_arready_o;
    logic [1:0]                 req_rvalid_o;
    logic [XLEN-1:0]            req_rdata_o;
    logic [1:0]                 req_rready_i;

    logic                       mem_arvalid_o;
    logic                       mem_arready_i;
    logic [ADDR_WIDTH-1:0]      mem_araddr_o;
    logic                       mem_rvalid_i;
    logic [XLEN-1:0]            mem_rdata_i;
    logic                       mem_rready_o;

    modport slave (
        input  req_arvalid_i,
        input  req_araddr_i,
        output req_arready_o,
        output req_rvalid_o,
        output req_rdata_o,
        input  req_rready_i,
        output mem_arvalid_o,
        input  mem_arready_i,
        output mem_araddr_o,
        input  mem_rvalid_i,
        input  mem_rdata_i,
        output mem_rready_o
    );

    modport master (
        output req_arvalid_i,
        output req_araddr_i,
        input  req_arready_o,
        input  req_rvalid_o,
        input  req_rdata_o,
        output req_rready_i,
        input  mem_arvalid_o,
        output mem_arready_i,
        input  mem_araddr_o,
        output mem_rvalid_i,
        output mem_rdata_i,
        input  mem_rready_o
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick, purely combinational.
//   req_i  - request vector (bit 0 icache, bit 1 dcache)
//   prio_i - index of the requester favoured when both request
//   gnt_o  - one-hot grant, zero when nothing requests
module rr_arbiter2
    import riscv_core_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       prio_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        // A lone requester wins regardless of the pointer.
        gnt_o = req_i;
        if (req_i[REQ_ICACHE] && req_i[REQ_DCACHE]) begin
            gnt_o = req_onehot(prio_i);
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Arbitrates burst line reads from an icache and a dcache onto one memory read port.
// One burst is in flight at a time: IDLE picks a winner round-robin and latches its
// address, ADDR presents it downstream, DATA forwards BEATS read beats to the owner.
//   clk_i, rst_i - clock and synchronous active-high reset
//   bus          - requester and memory channels (slave modport)
//   grant_o      - one-hot current owner, zero in IDLE
//   busy_o       - high whenever a burst is in progress
module mem_read_arbiter
    import riscv_core_pkg::*;
#(
    parameter int unsigned BEATS      = 8,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    mem_read_arbiter_if.slave   bus,
    output logic [1:0]          grant_o,
    output logic                busy_o
);

    localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);

    arb_state_e            state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            beat_q, beat_d;
    logic                  prio_q, prio_d;

    logic [1:0]            rr_gnt;
    logic                  owner;
    logic                  rready_sel;
    logic                  beat_fire;

    rr_arbiter2 u_rr (
        .req_i  (bus.req_arvalid_i),
        .prio_i (prio_q),
        .gnt_o  (rr_gnt)
    );

    assign owner      = grant_q[REQ_DCACHE];
    assign rready_sel = |(bus.req_rready_i & grant_q);
    assign beat_fire  = (state_q == StData) && bus.mem_rvalid_i && rready_sel;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        prio_d  = prio_q;

        bus.req_arready_o = '0;
        bus.req_rvalid_o  = '0;
        bus.req_rdata_o   = '0;
        bus.mem_arvalid_o = 1'b0;
        bus.mem_rready_o  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|bus.req_arvalid_i) begin
                    grant_d = rr_gnt;
                    addr_d  = rr_gnt[REQ_DCACHE] ? bus.req_araddr_i[REQ_DCACHE]
                                                 : bus.req_araddr_i[REQ_ICACHE];
                    state_d = StAddr;
                end
            end

            StAddr: begin
                bus.mem_arvalid_o = 1'b1;
                bus.req_arready_o = grant_q & {2{bus.mem_arready_i}};
                if (bus.mem_arready_i) begin
                    state_d = StData;
                end
            end

            StData: begin
                bus.req_rvalid_o = grant_q & {2{bus.mem_rvalid_i}};
                bus.req_rdata_o  = bus.mem_rdata_i;
                bus.mem_rready_o = rready_sel;
                if (beat_fire) begin
                    if (beat_q == LAST_BEAT) begin
                        // Burst done: release the bus and favour the other requester.
                        state_d = StIdle;
                        beat_d  = '0;
                        grant_d = '0;
                        prio_d  = ~owner;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end

            default: begin
                state_d = StIdle;
                grant_d = '0;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            grant_q <= '0;
            addr_q  <= '0;
            beat_q  <= '0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            prio_q  <= prio_d;
        end
    end

    // Address stays on the bus after the burst; only reset clears it.
    assign bus.mem_araddr_o = addr_q;
    assign grant_o          = grant_q;
    assign busy_o           = (state_q != StIdle);

    a_grant_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(grant_q));

    a_addr_stable : assert property (@(posedge clk_i) disable iff (rst_i)
        bus.mem_arvalid_o && !bus.mem_arready_i |=>
            bus.mem_arvalid_o && $stable(bus.mem_araddr_o));

endmodule
